// File: rtl/adc733_frame_buf.sv
// adc733_frame_buf: tags codec words with their channel index and queues them in a first-word-fall-through FIFO with drop accounting.
module adc733_frame_buf #(
    parameter int NUM_CH = 6,
    parameter int DEPTH  = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [15:0]   s_data,
    input  logic          s_valid,
    input  logic          frame_sync,
    input  logic          enable,
    input  logic          clear,
    output logic [15:0]   m_data,
    output logic [2:0]    m_channel,
    output logic          m_first,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [LW-1:0] level,
    output logic          overflow,
    output logic [7:0]    drop_cnt
);
    logic [2:0]    ch_cnt;
    logic [2:0]    tag;
    logic [LW-1:0] wr_ptr;
    logic [LW-1:0] rd_ptr;
    logic [19:0]   mem [DEPTH];
    logic [19:0]   head;
    logic          full;
    logic          wr_en;
    logic          rd_en;
    logic          drop;

    // a sync arriving with a sample claims that sample as channel 0
    assign tag     = frame_sync ? 3'd0 : ch_cnt;
    assign level   = wr_ptr - rd_ptr;
    assign full    = level == LW'(DEPTH);
    assign m_valid = level != '0;
    assign wr_en   = s_valid && enable && !full;
    assign drop    = s_valid && enable && full;
    assign rd_en   = m_valid && m_ready;
    assign head    = mem[rd_ptr[AW-1:0]];

    // head fields read as zero while empty so the outputs are clean after reset
    assign m_first   = m_valid & head[19];
    assign m_channel = m_valid ? head[18:16] : 3'd0;
    assign m_data    = m_valid ? head[15:0] : 16'd0;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            ch_cnt   <= 3'd0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
            drop_cnt <= 8'd0;
        end else begin
            // the counter tracks every strobe so alignment survives drops and enable=0
            if (s_valid)
                ch_cnt <= (tag == 3'(NUM_CH - 1)) ? 3'd0 : tag + 3'd1;
            else if (frame_sync)
                ch_cnt <= 3'd0;
            if (wr_en)
                wr_ptr <= wr_ptr + LW'(1);
            if (rd_en)
                rd_ptr <= rd_ptr + LW'(1);
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != 8'hFF)
                    drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !rst && !clear)
            mem[wr_ptr[AW-1:0]] <= {tag == 3'd0, tag, s_data};
    end
endmodule

// File: tb/tb_adc733_frame_buf.sv
// tb_adc733_frame_buf: directed stimulus checked against a queue-based reference model,
// plus hand-computed expectations on the sequence of words the consumer receives.
module tb_adc733_frame_buf;
    localparam int NUM_CH = 6;
    localparam int DEPTH  = 16;
    localparam int LW     = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [15:0]   s_data = 16'd0;
    logic          s_valid = 1'b0;
    logic          frame_sync = 1'b0;
    logic          enable = 1'b1;
    logic          clear = 1'b0;
    logic          m_ready = 1'b1;
    logic [15:0]   m_data;
    logic [2:0]    m_channel;
    logic          m_first;
    logic          m_valid;
    logic [LW-1:0] level;
    logic          overflow;
    logic [7:0]    drop_cnt;

    adc733_frame_buf #(.NUM_CH(NUM_CH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid),
        .frame_sync(frame_sync), .enable(enable), .clear(clear),
        .m_data(m_data), .m_channel(m_channel), .m_first(m_first),
        .m_valid(m_valid), .m_ready(m_ready), .level(level),
        .overflow(overflow), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit started = 1'b0;

    logic [19:0] q[$];
    logic [19:0] seen[$];
    int mch = 0;
    int mdrop = 0;
    bit movf = 1'b0;

    task automatic chk(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // reference model: a plain queue of {first, channel, data} entries
    always @(posedge clk) begin
        int tag;
        bit full;
        bit rd;
        bit wr;
        if (rst || clear) begin
            q.delete();
            mch = 0;
            mdrop = 0;
            movf = 1'b0;
        end else begin
            tag = frame_sync ? 0 : mch;
            if (s_valid) mch = (tag + 1) % NUM_CH;
            else if (frame_sync) mch = 0;
            full = q.size() == DEPTH;
            rd = q.size() != 0 && m_ready;
            wr = s_valid && enable && !full;
            if (s_valid && enable && full) begin
                movf = 1'b1;
                if (mdrop < 255) mdrop++;
            end
            if (rd) void'(q.pop_front());
            if (wr) q.push_back({tag == 0, 3'(tag), s_data});
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("m_valid", int'(m_valid), int'(q.size() != 0));
            chk("level", int'(level), q.size());
            chk("overflow", int'(overflow), int'(movf));
            chk("drop_cnt", int'(drop_cnt), mdrop);
            if (q.size() != 0) begin
                chk("m_data", int'(m_data), int'(q[0][15:0]));
                chk("m_channel", int'(m_channel), int'(q[0][18:16]));
                chk("m_first", int'(m_first), int'(q[0][19]));
            end
            if (m_valid && m_ready && !clear && !rst)
                seen.push_back({m_first, m_channel, m_data});
        end
    end

    task automatic cyc(int n = 1);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic strobe(logic [15:0] d, bit fs = 1'b0);
        s_valid = 1'b1;
        s_data = d;
        frame_sync = fs;
        cyc();
        s_valid = 1'b0;
        frame_sync = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        cyc(2);
        started = 1'b1;
        rst = 1'b0;
        chk("reset_level", int'(level), 0);
        chk("reset_valid", int'(m_valid), 0);

        // tagging and wrap
        frame_sync = 1'b1;
        cyc();
        frame_sync = 1'b0;
        for (int i = 0; i < 13; i++) strobe(16'h1000 + 16'(i));
        cyc(2);
        chk("t1_count", seen.size(), 13);
        chk("t1_w0", int'(seen[0]), 'h81000);
        chk("t1_w5", int'(seen[5]), 'h51005);
        chk("t1_w6", int'(seen[6]), 'h81006);
        chk("t1_w12", int'(seen[12]), 'h8100C);

        // resync mid-frame
        seen.delete();
        for (int i = 0; i < 3; i++) strobe(16'h2000 + 16'(i));
        strobe(16'hBEEF, 1'b1);
        strobe(16'h2003);
        cyc(2);
        chk("t2_sync", int'(seen[3]), 'h8BEEF);
        chk("t2_next", int'(seen[4]), 'h12003);

        // fill and overflow, then drain
        frame_sync = 1'b1;
        cyc();
        frame_sync = 1'b0;
        m_ready = 1'b0;
        for (int i = 0; i < DEPTH + 3; i++) strobe(16'h3000 + 16'(i));
        cyc();
        chk("t3_level", int'(level), 16);
        chk("t3_ovf", int'(overflow), 1);
        chk("t3_drops", int'(drop_cnt), 3);
        seen.delete();
        m_ready = 1'b1;
        cyc(18);
        chk("t3_count", seen.size(), 16);
        chk("t3_w0", int'(seen[0]), 'h83000);
        chk("t3_w15", int'(seen[15]), 'h3300F);
        strobe(16'h5000);
        cyc(2);
        chk("t3_cont", int'(seen[16]), 'h15000);

        // full with simultaneous read and write
        m_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) strobe(16'h6000 + 16'(i));
        m_ready = 1'b1;
        strobe(16'h6FFF);
        m_ready = 1'b0;
        chk("t4_level", int'(level), 15);
        chk("t4_drops", int'(drop_cnt), 4);
        chk("t4_head", int'(m_data), 'h6001);

        // enable and clear
        m_ready = 1'b1;
        cyc(16);
        frame_sync = 1'b1;
        cyc();
        frame_sync = 1'b0;
        enable = 1'b0;
        for (int i = 0; i < 4; i++) strobe(16'h70A0 + 16'(i));
        chk("t5_level", int'(level), 0);
        chk("t5_drops", int'(drop_cnt), 4);
        enable = 1'b1;
        seen.delete();
        strobe(16'h7100);
        cyc();
        clear = 1'b1;
        strobe(16'h7200);
        clear = 1'b0;
        chk("t5_clr_level", int'(level), 0);
        chk("t5_clr_valid", int'(m_valid), 0);
        chk("t5_clr_ovf", int'(overflow), 0);
        chk("t5_clr_drops", int'(drop_cnt), 0);
        strobe(16'h7300);
        cyc();
        chk("t5_count", seen.size(), 2);
        chk("t5_adv", int'(seen[0]), 'h47100);
        chk("t5_tag0", int'(seen[1]), 'h87300);

        // drop counter saturation, then reset
        m_ready = 1'b0;
        for (int i = 0; i < DEPTH + 300; i++) strobe(16'h8000 + 16'(i));
        chk("t6_drops", int'(drop_cnt), 255);
        chk("t6_ovf", int'(overflow), 1);
        chk("t6_level", int'(level), 16);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("t6_rst_valid", int'(m_valid), 0);
        chk("t6_rst_level", int'(level), 0);
        chk("t6_rst_ovf", int'(overflow), 0);
        chk("t6_rst_drops", int'(drop_cnt), 0);
        chk("t6_rst_data", int'(m_data), 0);
        chk("t6_rst_chan", int'({m_first, m_channel}), 0);
        cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
